// File: rtl/sd_dat_phys_ctrl_mb.sv
// SD DAT-line physical controller, multi-block capable.
// Sequences serializer/deserializer, DAT pad and FIFOs per block.
module sd_dat_phys_ctrl_mb #(
    parameter int DATA_W    = 32,
    parameter int BLKCNT_W  = 8,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 sd_clock,
    input  logic                 reset,
    input  logic                 strobe_in,
    input  logic                 ack_in,
    input  logic                 abort_in,
    input  logic                 write_read,
    input  logic                 multiple,
    input  logic [BLKCNT_W-1:0]  blocks,
    input  logic [TIMEOUT_W-1:0] timeout_reg,
    output logic                 serial_ready,
    output logic                 complete,
    output logic                 ack_out,
    output logic                 data_timeout,
    output logic                 crc_error,
    output logic [BLKCNT_W-1:0]  blocks_done,
    input  logic                 tx_done,
    input  logic                 rx_done,
    input  logic                 crc_status_ok,
    input  logic [DATA_W-1:0]    data_read,
    output logic                 reset_wrapper,
    output logic                 load_send,
    output logic                 enable_pts,
    output logic                 enable_stp,
    output logic                 pad_state,
    output logic                 pad_enable,
    output logic                 fifo_rd_en,
    input  logic                 fifo_empty,
    output logic                 fifo_wr_en,
    output logic [DATA_W-1:0]    fifo_wr_data,
    input  logic                 fifo_full
);

    typedef enum logic [3:0] {
        ST_RST,
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_STATUS,
        ST_READ,
        ST_READ_PUSH,
        ST_TURN,
        ST_WAIT_ACK
    } state_t;

    state_t               state;
    logic                 dir_write;
    logic [BLKCNT_W-1:0]  last_blk;
    logic [TIMEOUT_W-1:0] tmo_cnt;

    logic [BLKCNT_W-1:0]  blk_inc;
    logic [BLKCNT_W-1:0]  blk_req;
    logic [BLKCNT_W-1:0]  last_next;
    logic [TIMEOUT_W-1:0] tmo_inc;
    logic                 tmo_run;
    logic                 tmo_hit;
    logic                 abort_ok;

    // Next-count helpers: saturating increments and the timeout match.
    always_comb begin
        blk_inc   = (&blocks_done) ? blocks_done : blocks_done + 1'b1;
        blk_req   = (blocks == '0) ? BLKCNT_W'(1) : blocks;
        last_next = multiple ? blk_req : BLKCNT_W'(1);
        tmo_run   = (state == ST_WAIT_STATUS) || (state == ST_READ);
        tmo_inc   = (&tmo_cnt) ? tmo_cnt : tmo_cnt + 1'b1;
        tmo_hit   = tmo_run && (timeout_reg != '0) && (tmo_inc == timeout_reg);
        abort_ok  = abort_in && (state != ST_RST) && (state != ST_IDLE);
    end

    // Transfer FSM with block counter, timeout counter and sticky flags.
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state        <= ST_RST;
            dir_write    <= 1'b0;
            last_blk     <= '0;
            tmo_cnt      <= '0;
            blocks_done  <= '0;
            data_timeout <= 1'b0;
            crc_error    <= 1'b0;
        end else begin
            // Counter only runs in the two waiting states; any other
            // state clears it, so every entry starts from zero.
            tmo_cnt <= tmo_run ? tmo_inc : '0;
            if (abort_ok) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_RST: begin
                        state <= ST_IDLE;
                    end
                    ST_IDLE: begin
                        if (strobe_in) begin
                            data_timeout <= 1'b0;
                            crc_error    <= 1'b0;
                            blocks_done  <= '0;
                            last_blk     <= last_next;
                            dir_write    <= write_read;
                            state <= write_read ? ST_LOAD : ST_READ;
                        end
                    end
                    ST_LOAD: begin
                        if (!fifo_empty) begin
                            state <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (tx_done) begin
                            state <= ST_WAIT_STATUS;
                        end
                    end
                    ST_WAIT_STATUS: begin
                        if (tmo_hit) begin
                            data_timeout <= 1'b1;
                            state        <= ST_WAIT_ACK;
                        end else if (rx_done) begin
                            if (!crc_status_ok) begin
                                crc_error <= 1'b1;
                                state     <= ST_WAIT_ACK;
                            end else begin
                                blocks_done <= blk_inc;
                                state <= (blk_inc == last_blk) ?
                                         ST_WAIT_ACK : ST_TURN;
                            end
                        end
                    end
                    ST_READ: begin
                        if (tmo_hit) begin
                            data_timeout <= 1'b1;
                            state        <= ST_WAIT_ACK;
                        end else if (rx_done) begin
                            state <= ST_READ_PUSH;
                        end
                    end
                    ST_READ_PUSH: begin
                        if (!fifo_full) begin
                            blocks_done <= blk_inc;
                            state <= (blk_inc == last_blk) ?
                                     ST_WAIT_ACK : ST_TURN;
                        end
                    end
                    ST_TURN: begin
                        state <= dir_write ? ST_LOAD : ST_READ;
                    end
                    ST_WAIT_ACK: begin
                        if (ack_in) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_RST;
                    end
                endcase
            end
        end
    end

    // Output decode from the registered state; FIFO strobes gated by flow control.
    always_comb begin
        serial_ready  = 1'b0;
        complete      = 1'b0;
        ack_out       = 1'b0;
        reset_wrapper = 1'b0;
        load_send     = 1'b0;
        enable_pts    = 1'b0;
        enable_stp    = 1'b0;
        pad_state     = 1'b0;
        pad_enable    = 1'b0;
        fifo_rd_en    = 1'b0;
        fifo_wr_en    = 1'b0;
        fifo_wr_data  = '0;
        unique case (state)
            ST_IDLE: begin
                serial_ready  = 1'b1;
                reset_wrapper = 1'b1;
            end
            ST_LOAD: begin
                enable_pts = 1'b1;
                pad_state  = 1'b1;
                pad_enable = 1'b1;
                fifo_rd_en = !fifo_empty;
            end
            ST_SEND: begin
                load_send  = 1'b1;
                enable_pts = 1'b1;
                pad_state  = 1'b1;
                pad_enable = 1'b1;
            end
            ST_WAIT_STATUS: begin
                pad_enable = 1'b1;
                enable_stp = 1'b1;
            end
            ST_READ: begin
                enable_stp = 1'b1;
                pad_enable = 1'b1;
            end
            ST_READ_PUSH: begin
                fifo_wr_data = data_read;
                fifo_wr_en   = !fifo_full;
            end
            ST_TURN: begin
                reset_wrapper = 1'b1;
            end
            ST_WAIT_ACK: begin
                complete = 1'b1;
                ack_out  = ack_in;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_sd_dat_phys_ctrl_mb.sv
// Bench for sd_dat_phys_ctrl_mb.
// Read words are scoreboarded from rx_done to the FIFO push.
module tb_sd_dat_phys_ctrl_mb;

    localparam int DW = 32;
    localparam int BW = 8;
    localparam int TW = 16;

    logic          sd_clock = 1'b0;
    logic          reset = 1'b1;
    logic          strobe_in = 1'b0;
    logic          ack_in = 1'b0;
    logic          abort_in = 1'b0;
    logic          write_read = 1'b0;
    logic          multiple = 1'b0;
    logic [BW-1:0] blocks = '0;
    logic [TW-1:0] timeout_reg = '0;
    logic          serial_ready;
    logic          complete;
    logic          ack_out;
    logic          data_timeout;
    logic          crc_error;
    logic [BW-1:0] blocks_done;
    logic          tx_done = 1'b0;
    logic          rx_done = 1'b0;
    logic          crc_status_ok = 1'b1;
    logic [DW-1:0] data_read = '0;
    logic          reset_wrapper;
    logic          load_send;
    logic          enable_pts;
    logic          enable_stp;
    logic          pad_state;
    logic          pad_enable;
    logic          fifo_rd_en;
    logic          fifo_empty = 1'b1;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_wr_data;
    logic          fifo_full = 1'b0;

    int n_total = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int rd_base;
    int wr_base;
    logic [DW-1:0] sb_q[$];

    sd_dat_phys_ctrl_mb #(
        .DATA_W(DW),
        .BLKCNT_W(BW),
        .TIMEOUT_W(TW)
    ) dut (
        .sd_clock(sd_clock),
        .reset(reset),
        .strobe_in(strobe_in),
        .ack_in(ack_in),
        .abort_in(abort_in),
        .write_read(write_read),
        .multiple(multiple),
        .blocks(blocks),
        .timeout_reg(timeout_reg),
        .serial_ready(serial_ready),
        .complete(complete),
        .ack_out(ack_out),
        .data_timeout(data_timeout),
        .crc_error(crc_error),
        .blocks_done(blocks_done),
        .tx_done(tx_done),
        .rx_done(rx_done),
        .crc_status_ok(crc_status_ok),
        .data_read(data_read),
        .reset_wrapper(reset_wrapper),
        .load_send(load_send),
        .enable_pts(enable_pts),
        .enable_stp(enable_stp),
        .pad_state(pad_state),
        .pad_enable(pad_enable),
        .fifo_rd_en(fifo_rd_en),
        .fifo_empty(fifo_empty),
        .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data),
        .fifo_full(fifo_full)
    );

    always #5 sd_clock = ~sd_clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Per-cycle observation of the FIFO strobes at the falling edge.
    task automatic mon();
        logic [DW-1:0] e;
        if (fifo_rd_en === 1'b1) rd_cnt++;
        if (fifo_full) chk("nopush_full", 32'(fifo_wr_en), 0);
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 1);
            end else begin
                e = sb_q.pop_front();
                chk("push_data", fifo_wr_data, e);
            end
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge sd_clock);
            mon();
            @(posedge sd_clock);
            #1;
        end
    endtask

    task automatic start(input logic wr, input logic mul,
                         input logic [BW-1:0] nb);
        write_read = wr;
        multiple   = mul;
        blocks     = nb;
        strobe_in  = 1'b1;
        rd_base    = rd_cnt;
        wr_base    = wr_cnt;
        tick(1);
        strobe_in  = 1'b0;
    endtask

    task automatic finish_ack();
        ack_in = 1'b1;
        #1;
        chk("ack_out", 32'(ack_out), 1);
        tick(1);
        ack_in = 1'b0;
        chk("back_idle", 32'(serial_ready), 1);
    endtask

    // Drive one read block: wait, deliver a word, optional FIFO stall.
    task automatic read_block(input int stall);
        tick(1);
        data_read = $urandom;
        sb_q.push_back(data_read);
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        if (stall > 0) begin
            fifo_full = 1'b1;
            tick(stall);
            fifo_full = 1'b0;
        end
        tick(1);
    endtask

    // Drive one write block up to the status token.
    task automatic write_block(input logic ok);
        tick(1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        tick(1);
        crc_status_ok = ok;
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        crc_status_ok = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        chk("rst_ready", 32'(serial_ready), 0);
        chk("rst_rstwrap", 32'(reset_wrapper), 0);
        chk("rst_blocks", 32'(blocks_done), 0);
        chk("rst_complete", 32'(complete), 0);
        reset = 1'b0;
        tick(1);
        chk("idle_ready", 32'(serial_ready), 1);
        chk("idle_rstwrap", 32'(reset_wrapper), 1);

        // Single write with a two-cycle empty-FIFO stall in LOAD.
        start(1'b1, 1'b0, 8'd0);
        tick(2);
        chk("load_stall_pts", 32'(enable_pts), 1);
        chk("load_stall_rd", 32'(rd_cnt - rd_base), 0);
        fifo_empty = 1'b0;
        tick(1);
        chk("send_load", 32'(load_send), 1);
        chk("send_pad", 32'(pad_state), 1);
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        chk("ws_pad_rel", 32'(pad_state), 0);
        chk("ws_stp", 32'(enable_stp), 1);
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        chk("w1_complete", 32'(complete), 1);
        chk("w1_blocks", 32'(blocks_done), 1);
        chk("w1_crc", 32'(crc_error), 0);
        chk("w1_rd_pulses", 32'(rd_cnt - rd_base), 1);
        finish_ack();

        // Multi read of 3 blocks, FIFO full for 5 cycles on block 2.
        start(1'b0, 1'b1, 8'd3);
        read_block(0);
        chk("r3_turn", 32'(reset_wrapper), 1);
        tick(1);
        read_block(5);
        chk("r3_blk2", 32'(blocks_done), 2);
        tick(1);
        read_block(0);
        chk("r3_complete", 32'(complete), 1);
        chk("r3_blocks", 32'(blocks_done), 3);
        chk("r3_pushes", 32'(wr_cnt - wr_base), 3);
        chk("r3_sb_empty", 32'(sb_q.size()), 0);
        finish_ack();

        // Read timeout of 10 cycles; rx_done on the expiry cycle loses.
        timeout_reg = 16'd10;
        start(1'b0, 1'b0, 8'd1);
        tick(9);
        chk("to_early", 32'(data_timeout), 0);
        chk("to_in_read", 32'(enable_stp), 1);
        rx_done = 1'b1;
        tick(1);
        rx_done = 1'b0;
        chk("to_flag", 32'(data_timeout), 1);
        chk("to_complete", 32'(complete), 1);
        chk("to_blocks", 32'(blocks_done), 0);
        chk("to_nopush", 32'(wr_cnt - wr_base), 0);
        finish_ack();
        timeout_reg = '0;

        // Multi write of 4 with a bad CRC status on block 2.
        start(1'b1, 1'b1, 8'd4);
        chk("strobe_clr_to", 32'(data_timeout), 0);
        write_block(1'b1);
        tick(1);
        write_block(1'b0);
        chk("crc_flag", 32'(crc_error), 1);
        chk("crc_blocks", 32'(blocks_done), 1);
        chk("crc_complete", 32'(complete), 1);
        tick(5);
        chk("crc_rd_pulses", 32'(rd_cnt - rd_base), 2);
        finish_ack();

        // Abort during SEND of block 2 of 3.
        start(1'b1, 1'b1, 8'd3);
        chk("strobe_clr_crc", 32'(crc_error), 0);
        chk("strobe_clr_blk", 32'(blocks_done), 0);
        write_block(1'b1);
        tick(2);
        chk("ab_in_send", 32'(load_send), 1);
        abort_in = 1'b1;
        tick(1);
        abort_in = 1'b0;
        chk("ab_ready", 32'(serial_ready), 1);
        chk("ab_rstwrap", 32'(reset_wrapper), 1);
        chk("ab_blocks_held", 32'(blocks_done), 1);

        // blocks=0 with multiple=1 moves exactly one block.
        start(1'b0, 1'b1, 8'd0);
        chk("b0_clr_blk", 32'(blocks_done), 0);
        read_block(0);
        chk("b0_complete", 32'(complete), 1);
        chk("b0_blocks", 32'(blocks_done), 1);
        chk("b0_pushes", 32'(wr_cnt - wr_base), 1);
        finish_ack();

        // Reset in the middle of READ.
        start(1'b0, 1'b0, 8'd1);
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("mr_ready", 32'(serial_ready), 0);
        chk("mr_stp", 32'(enable_stp), 0);
        chk("mr_pad_en", 32'(pad_enable), 0);
        chk("mr_rstwrap", 32'(reset_wrapper), 0);
        chk("mr_complete", 32'(complete), 0);
        reset = 1'b0;
        tick(1);
        chk("mr_idle", 32'(serial_ready), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
